round_sequencer: RTL and testbench
==================================

// Module: round_sequencer
// PURPOSE
//  Game-round controller for the two-player bell game. Deals card pair (c1/n1, c2/n2), runs per-round
//  countdown, arbitrates bell presses (P1 key 4'b0111, P2 key 4'b1001) and judges each press.
//  Drives who/right into score_control, handshakes on its finish, stops game on win or round limit.
// PARAMETERS
//  COUNT_INIT  8'd99        countdown start value per deal; value at press = points awarded
//  TICK_DIV    1000         clk cycles per countdown decrement (>=2)
//  MAX_ROUNDS  8'd20        deals per game; game ends after this round completes
//  LFSR_SEED   16'hACE1     card LFSR reset value (must be nonzero)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous reset, active-low
//  start      in   1  level; sampled in IDLE to begin game
//  keypad_in  in   4  raw keypad code
//  finish     in   1  score_control done flag (handshake return)
//  win_sig    in   2  who_win LCD_sig; nonzero = winner decided
//  c1, c2     out  2  card colours
//  n1, n2     out  3  card numbers, always 1..5 after first deal
//  count      out  8  countdown value
//  who        out  2  01=P1, 10=P2, 00=none; to score_control
//  right      out  1  judgement of latched press
//  round      out  8  deals issued this game
//  lock       out  2  [0]=P1 locked, [1]=P2 locked
//  game_over  out  1  game ended; held until reset
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; c1,c2,n1,n2,count,who,right,round,lock,game_over all 0; LFSR=LFSR_SEED.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle incl. IDLE; never all-zero.
//  Card map at DEAL: c1=L[4:3], c2=L[12:11]; n=(v>=5)?v-4:v+1, v=L[2:0] for n1, L[10:8] for n2.
//  Press detect: key_q registered every cycle; P1 press = keypad_in==0111 && key_q!=0111 (same for P2).
//   Held key never re-triggers. Presses outside WAIT, or by a locked player, discarded (not queued).
//  Judge (combinational on current cards): right = (c1==c2) ? (n1+n2==5, 4-bit sum) : (n1==5 || n2==5).
//  States:
//   IDLE    : outputs static. start=1 -> DEAL.
//   DEAL    : 1 cycle. load cards, count<=COUNT_INIT, tick<=0, lock<=00, round<=round+1 -> WAIT.
//   WAIT    : tick++; at tick==TICK_DIV-1: tick<=0, count<=count-1 (saturating at 0).
//             valid press -> SCORE, latch who and right (count frozen same cycle).
//             count==0 at tick expiry, no press -> NEXT (no score).
//             press and expiry same cycle: press wins.
//   SCORE   : hold who/right until finish==1 -> REL.
//   REL     : who<=00; wait finish==0. right latched=1 -> NEXT.
//             right=0: lock presser; both locked -> NEXT, else -> WAIT (same cards, count resumes).
//   NEXT    : 1 cycle. win_sig!=00 or round==MAX_ROUNDS -> OVER, else -> DEAL.
//   OVER    : game_over=1, who=00, all else frozen; exit only by reset.
//  Latency: press-to-who = 1 clk; deal-to-WAIT = 1 clk. who never nonzero outside SCORE.
//  round is 8-bit, no wrap (MAX_ROUNDS<=255). start ignored outside IDLE.
//  Reset mid-SCORE: who drops immediately (async); no partial handshake survives.
// TESTING
//  T1 reset: rst=0 mid-WAIT -> all outputs 0, state IDLE same cycle; LFSR restarts at ACE1.
//  T2 TICK_DIV=4, COUNT_INIT=3, no keys -> count 3,2,1,0 every 4 clk, then new DEAL, round 1->2.
//  T3 cards c1=c2, n1=2,n2=3; P1 press at count=2 -> who=01,right=1 next clk; finish 1->0 -> DEAL.
//  T4 cards c1!=c2, n1=1,n2=2; P2 press -> right=0, lock=10, back to WAIT; P2 re-press ignored;
//     P1 press -> who=01; if also wrong -> lock=11 -> next DEAL, lock cleared.
//  T5 P1 holds 0111 across DEAL -> no second press; release and re-press -> accepted.
//  T6 win_sig=01 during REL -> NEXT -> OVER, game_over=1; start and keys ignored until rst.

Source files
------------

// File: rtl/round_sequencer.sv
// -----------------------------------------------------------------------------
// round_sequencer
//
// Game-round controller for the two-player bell game. Deals a card pair from a
// free-running LFSR, runs a per-round countdown, arbitrates bell presses from
// the keypad, judges each press and hands the result to score_control. The
// game stops on a declared winner or after MAX_ROUNDS deals.
//
// Ports
//   clk        in   1  system clock
//   rst        in   1  asynchronous reset, active-low
//   start      in   1  level, sampled in IDLE to begin a game
//   keypad_in  in   4  raw keypad code (P1 bell 4'b0111, P2 bell 4'b1001)
//   finish     in   1  score_control done flag
//   win_sig    in   2  nonzero once a winner is decided
//   c1, c2     out  2  card colours
//   n1, n2     out  3  card numbers, 1..5 after the first deal
//   count      out  8  countdown value (points for a correct press)
//   who        out  2  01=P1, 10=P2, 00=none
//   right      out  1  judgement of the latched press
//   round      out  8  deals issued this game
//   lock       out  2  [0]=P1 locked, [1]=P2 locked for the current deal
//   game_over  out  1  game ended, held until reset
//
// Handshake with score_control: who!=00 is the request (valid) and is only
// ever nonzero in SCORE; it is held together with right until finish is seen
// high (ready/done). who then drops, and the sequencer waits for finish to
// return low before acting on the judgement, so one press is scored once.
// -----------------------------------------------------------------------------
module round_sequencer #(
    parameter logic [7:0]  COUNT_INIT = 8'd99,
    parameter int          TICK_DIV   = 1000,
    parameter logic [7:0]  MAX_ROUNDS = 8'd20,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] keypad_in,
    input  logic       finish,
    input  logic [1:0] win_sig,
    output logic [1:0] c1,
    output logic [1:0] c2,
    output logic [2:0] n1,
    output logic [2:0] n2,
    output logic [7:0] count,
    output logic [1:0] who,
    output logic       right,
    output logic [7:0] round,
    output logic [1:0] lock,
    output logic       game_over
);

    localparam logic [3:0] KEY_P1 = 4'b0111;
    localparam logic [3:0] KEY_P2 = 4'b1001;
    localparam int         TW     = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEAL,
        S_WAIT,
        S_SCORE,
        S_REL,
        S_NEXT,
        S_OVER
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [15:0]   lfsr;
    logic [15:0]   lfsr_nxt;
    logic [3:0]    key_q;
    logic [TW-1:0] tick;
    logic [1:0]    presser;

    logic p1_take;
    logic p2_take;
    logic press_take;
    logic tick_last;
    logic judge;

    // Map a 3-bit LFSR field onto a card number 1..5.
    function automatic logic [2:0] card_num(input logic [2:0] v);
        return (v >= 3'd5) ? (v - 3'd4) : (v + 3'd1);
    endfunction

    // Fibonacci LFSR, taps 16,14,13,11 (bit 0 is the output end).
    assign lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

    // A press is the first cycle a bell code appears; a held key never
    // re-triggers. Locked players are ignored.
    assign p1_take    = (keypad_in == KEY_P1) && (key_q != KEY_P1) && !lock[0];
    assign p2_take    = (keypad_in == KEY_P2) && (key_q != KEY_P2) && !lock[1];
    assign press_take = p1_take || p2_take;
    assign tick_last  = (tick == TICK_LAST);

    // Same colour: the numbers must sum to five. Different colours: a five
    // must be showing.
    assign judge = (c1 == c2) ? (({1'b0, n1} + {1'b0, n2}) == 4'd5)
                              : ((n1 == 3'd5) || (n2 == 3'd5));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_DEAL;
            S_DEAL:  state_nxt = S_WAIT;
            S_WAIT: begin
                // A press in the same cycle as the final expiry still wins.
                if (press_take)                        state_nxt = S_SCORE;
                else if (tick_last && (count == 8'd0)) state_nxt = S_NEXT;
            end
            S_SCORE: if (finish) state_nxt = S_REL;
            S_REL: begin
                if (!finish) begin
                    if (right)                          state_nxt = S_NEXT;
                    else if ((lock | presser) == 2'b11) state_nxt = S_NEXT;
                    else                                state_nxt = S_WAIT;
                end
            end
            S_NEXT: begin
                if ((win_sig != 2'b00) || (round == MAX_ROUNDS)) state_nxt = S_OVER;
                else                                             state_nxt = S_DEAL;
            end
            S_OVER:  state_nxt = S_OVER;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr      <= LFSR_SEED;
            key_q     <= 4'd0;
            tick      <= '0;
            presser   <= 2'b00;
            c1        <= 2'd0;
            c2        <= 2'd0;
            n1        <= 3'd0;
            n2        <= 3'd0;
            count     <= 8'd0;
            who       <= 2'b00;
            right     <= 1'b0;
            round     <= 8'd0;
            lock      <= 2'b00;
            game_over <= 1'b0;
        end else begin
            lfsr  <= lfsr_nxt;
            key_q <= keypad_in;
            case (state)
                S_DEAL: begin
                    c1    <= lfsr[4:3];
                    c2    <= lfsr[12:11];
                    n1    <= card_num(lfsr[2:0]);
                    n2    <= card_num(lfsr[10:8]);
                    count <= COUNT_INIT;
                    tick  <= '0;
                    lock  <= 2'b00;
                    round <= round + 8'd1;
                end
                S_WAIT: begin
                    if (press_take) begin
                        // Countdown and tick freeze on the press cycle; the
                        // frozen count is the value being awarded.
                        who     <= p1_take ? 2'b01 : 2'b10;
                        presser <= p1_take ? 2'b01 : 2'b10;
                        right   <= judge;
                    end else if (tick_last) begin
                        tick <= '0;
                        if (count != 8'd0) count <= count - 8'd1;
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                S_SCORE: begin
                    if (finish) who <= 2'b00;
                end
                S_REL: begin
                    if (!finish && !right) lock <= lock | presser;
                end
                S_NEXT: begin
                    if (state_nxt == S_OVER) game_over <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_round_sequencer
//
// Directed bench for round_sequencer with a short countdown (COUNT_INIT=3,
// TICK_DIV=4, MAX_ROUNDS=3). A procedural game model follows the rules of the
// game step by step and is compared against every output on each falling
// edge; directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_round_sequencer;

    localparam logic [7:0]  CI   = 8'd3;
    localparam int          TD   = 4;
    localparam logic [7:0]  MR   = 8'd3;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] keypad_in;
    logic       finish;
    logic [1:0] win_sig;
    logic [1:0] c1, c2;
    logic [2:0] n1, n2;
    logic [7:0] count;
    logic [1:0] who;
    logic       right;
    logic [7:0] round;
    logic [1:0] lock;
    logic       game_over;

    int checks;
    int failures;
    bit checks_on;

    round_sequencer #(
        .COUNT_INIT(CI),
        .TICK_DIV  (TD),
        .MAX_ROUNDS(MR),
        .LFSR_SEED (SEED)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .keypad_in(keypad_in),
        .finish   (finish),
        .win_sig  (win_sig),
        .c1       (c1),
        .c2       (c2),
        .n1       (n1),
        .n2       (n2),
        .count    (count),
        .who      (who),
        .right    (right),
        .round    (round),
        .lock     (lock),
        .game_over(game_over)
    );

    // ---------------------------------------------------------------- clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ----------------------------------------------------------- comparison
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ----------------------------------------------------------- game model
    logic [1:0]  m_c1, m_c2, m_who, m_lock;
    logic [2:0]  m_n1, m_n2;
    logic [7:0]  m_count, m_round;
    logic        m_right, m_go;
    logic [15:0] m_lfsr, s_lfsr;
    logic [3:0]  m_keyq;
    logic [1:0]  s_win;
    bit          s_start, s_fin, s_p1, s_p2, abort;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic b;
        b = v[0] ^ v[2] ^ v[3] ^ v[5];
        return (v >> 1) | {b, 15'd0};
    endfunction

    function automatic logic [2:0] card_num(input logic [2:0] v);
        int x;
        x = int'(v);
        if (x >= 5) x = x - 4;
        else        x = x + 1;
        return 3'(x);
    endfunction

    function automatic logic judge_m();
        int s;
        s = int'(m_n1) + int'(m_n2);
        if (m_c1 == m_c2) return (s == 5);
        return (m_n1 == 3'd5) || (m_n2 == 3'd5);
    endfunction

    task automatic m_reset();
        m_c1 = 0; m_c2 = 0; m_n1 = 0; m_n2 = 0;
        m_count = 0; m_who = 0; m_right = 0; m_round = 0;
        m_lock = 0; m_go = 0; m_lfsr = SEED; m_keyq = 4'd0;
    endtask

    // One active clock edge of the game, or an asynchronous reset.
    task automatic m_step();
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_reset();
            abort = 1'b1;
        end else begin
            s_start = start;
            s_fin   = finish;
            s_win   = win_sig;
            s_p1    = (keypad_in == 4'b0111) && (m_keyq != 4'b0111);
            s_p2    = (keypad_in == 4'b1001) && (m_keyq != 4'b1001);
            m_keyq  = keypad_in;
            s_lfsr  = m_lfsr;
            m_lfsr  = lfsr_step(m_lfsr);
        end
    endtask

    task automatic play_game();
        int         ticks;
        logic [1:0] presser;
        bit         got, expired, round_done;
        presser = 2'b00;
        do begin m_step(); if (abort) return; end while (!s_start);
        forever begin
            // deal
            m_step(); if (abort) return;
            m_c1 = s_lfsr[4:3];
            m_c2 = s_lfsr[12:11];
            m_n1 = card_num(s_lfsr[2:0]);
            m_n2 = card_num(s_lfsr[10:8]);
            m_count = CI;
            m_lock  = 2'b00;
            m_round = m_round + 8'd1;
            ticks   = 0;
            round_done = 0;
            while (!round_done) begin
                got = 0;
                expired = 0;
                while (!got && !expired) begin
                    m_step(); if (abort) return;
                    if (s_p1 && !m_lock[0])      begin got = 1; presser = 2'b01; end
                    else if (s_p2 && !m_lock[1]) begin got = 1; presser = 2'b10; end
                    if (got) begin
                        m_who   = presser;
                        m_right = judge_m();
                    end else if (ticks == TD - 1) begin
                        ticks = 0;
                        if (m_count == 8'd0) expired = 1;
                        else m_count = m_count - 8'd1;
                    end else begin
                        ticks++;
                    end
                end
                if (expired) begin
                    round_done = 1;
                end else begin
                    do begin m_step(); if (abort) return; end while (!s_fin);
                    m_who = 2'b00;
                    do begin m_step(); if (abort) return; end while (s_fin);
                    if (m_right) begin
                        round_done = 1;
                    end else begin
                        m_lock = m_lock | presser;
                        if (m_lock == 2'b11) round_done = 1;
                    end
                end
            end
            // between deals
            m_step(); if (abort) return;
            if ((s_win != 2'b00) || (m_round == MR)) begin
                m_go = 1'b1;
                forever begin m_step(); if (abort) return; end
            end
        end
    endtask

    initial begin
        m_reset();
        @(negedge rst);
        forever begin
            m_reset();
            abort = 1'b0;
            wait (rst === 1'b1);
            play_game();
        end
    end

    always @(negedge clk) begin
        if (checks_on) begin
            chk("model_c1",        int'(c1),        int'(m_c1));
            chk("model_c2",        int'(c2),        int'(m_c2));
            chk("model_n1",        int'(n1),        int'(m_n1));
            chk("model_n2",        int'(n2),        int'(m_n2));
            chk("model_count",     int'(count),     int'(m_count));
            chk("model_who",       int'(who),       int'(m_who));
            chk("model_right",     int'(right),     int'(m_right));
            chk("model_round",     int'(round),     int'(m_round));
            chk("model_lock",      int'(lock),      int'(m_lock));
            chk("model_game_over", int'(game_over), int'(m_go));
        end
    end

    // ------------------------------------------------------- driver tasks
    task automatic apply_reset(input logic hold_start);
        @(negedge clk);
        #2;
        rst = 1'b0;
        start = hold_start;
        keypad_in = 4'd0;
        finish = 1'b0;
        win_sig = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic bit want(input int mode, input logic [15:0] v);
        logic [1:0] a, b;
        logic [2:0] x, y;
        a = v[4:3];
        b = v[12:11];
        x = card_num(v[2:0]);
        y = card_num(v[10:8]);
        if (mode == 1) return (a == b) && (x == 3'd2) && (y == 3'd3);
        return (a != b) && (x == 3'd1) && (y == 3'd2);
    endfunction

    // Raise start on the cycle whose deal will show the wanted cards.
    task automatic steer(input string name, input int mode);
        bit found;
        found = 0;
        for (int i = 0; i < 3000; i++) begin
            if (want(mode, lfsr_step(m_lfsr))) begin
                found = 1;
                start = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(name, int'(found), 1);
    endtask

    // Seed ACE1 -> one shift to 5670 before the deal: c1=2 c2=2 n1=1 n2=2.
    task automatic pin_deal(input string tag);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_c1"},    int'(c1),    2);
        chk({tag, "_c2"},    int'(c2),    2);
        chk({tag, "_n1"},    int'(n1),    1);
        chk({tag, "_n2"},    int'(n2),    2);
        chk({tag, "_count"}, int'(count), 3);
        chk({tag, "_round"}, int'(round), 1);
        chk({tag, "_lock"},  int'(lock),  0);
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin
        checks = 0;
        failures = 0;
        checks_on = 0;
        rst = 1'b1;
        start = 1'b0;
        keypad_in = 4'd0;
        finish = 1'b0;
        win_sig = 2'b00;
        #1 rst = 1'b0;
        #1 checks_on = 1;
        repeat (2) @(negedge clk);
        chk("reset_count",     int'(count),     0);
        chk("reset_round",     int'(round),     0);
        chk("reset_who",       int'(who),       0);
        chk("reset_game_over", int'(game_over), 0);

        // Deal straight out of reset: pins the LFSR seed and card mapping.
        start = 1'b1;
        rst = 1'b1;
        pin_deal("pin");

        // Countdown with no keys, then the next deal.
        repeat (4) @(negedge clk);
        chk("t2_count_2", int'(count), 2);
        repeat (12) @(negedge clk);
        chk("t2_count_0", int'(count), 0);
        chk("t2_round_1", int'(round), 1);
        repeat (2) @(negedge clk);
        chk("t2_round_2", int'(round), 2);
        chk("t2_count_3", int'(count), 3);

        // Asynchronous reset in the middle of WAIT.
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t1_count", int'(count), 0);
        chk("t1_round", int'(round), 0);
        chk("t1_n1",    int'(n1),    0);
        chk("t1_c2",    int'(c2),    0);
        start = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        pin_deal("t1_restart");

        // Three unanswered rounds reach the round limit.
        for (int i = 0; i < 100 && game_over !== 1'b1; i++) @(negedge clk);
        chk("limit_game_over", int'(game_over), 1);
        chk("limit_round",     int'(round),     3);
        chk("limit_who",       int'(who),       0);

        // T3: matching colours 2+3, correct P1 press at count 2.
        apply_reset(1'b0);
        steer("t3_steer", 1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("t3_n1", int'(n1), 2);
        chk("t3_n2", int'(n2), 3);
        chk("t3_same_colour", int'(c1 == c2), 1);
        repeat (4) @(negedge clk);
        chk("t3_count_before", int'(count), 2);
        keypad_in = 4'b0111;
        @(negedge clk);
        chk("t3_who",   int'(who),   1);
        chk("t3_right", int'(right), 1);
        chk("t3_count_frozen", int'(count), 2);
        keypad_in = 4'd0;
        repeat (2) @(negedge clk);
        chk("t3_who_held", int'(who), 1);
        finish = 1'b1;
        @(negedge clk);
        chk("t3_who_released", int'(who), 0);
        finish = 1'b0;
        repeat (3) @(negedge clk);
        chk("t3_round_2", int'(round), 2);
        chk("t3_count_3", int'(count), 3);

        // T4: differing colours 1,2, both players press wrongly.
        apply_reset(1'b0);
        steer("t4_steer", 2);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("t4_n1", int'(n1), 1);
        chk("t4_n2", int'(n2), 2);
        repeat (2) @(negedge clk);
        keypad_in = 4'b1001;
        @(negedge clk);
        chk("t4_who_p2",   int'(who),   2);
        chk("t4_right_p2", int'(right), 0);
        keypad_in = 4'd0;
        finish = 1'b1;
        @(negedge clk);
        chk("t4_who_drop", int'(who), 0);
        finish = 1'b0;
        @(negedge clk);
        chk("t4_lock_p2", int'(lock), 2);
        keypad_in = 4'b1001;
        @(negedge clk);
        chk("t4_repress_ignored", int'(who), 0);
        keypad_in = 4'd0;
        @(negedge clk);
        keypad_in = 4'b0111;
        @(negedge clk);
        chk("t4_who_p1",   int'(who),   1);
        chk("t4_right_p1", int'(right), 0);
        keypad_in = 4'd0;
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        @(negedge clk);
        chk("t4_lock_both", int'(lock), 3);
        repeat (2) @(negedge clk);
        chk("t4_lock_cleared", int'(lock), 0);
        chk("t4_round_2",      int'(round), 2);

        // T5: P1 key held across the deal, then released and pressed.
        apply_reset(1'b0);
        keypad_in = 4'b0111;
        steer("t5_steer", 1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        repeat (3) @(negedge clk);
        chk("t5_held_no_press", int'(who), 0);
        keypad_in = 4'd0;
        @(negedge clk);
        keypad_in = 4'b0111;
        @(negedge clk);
        chk("t5_who",   int'(who),   1);
        chk("t5_right", int'(right), 1);
        keypad_in = 4'd0;
        finish = 1'b1;

        // T6: winner declared during release ends the game.
        @(negedge clk);
        finish = 1'b0;
        win_sig = 2'b01;
        repeat (2) @(negedge clk);
        chk("t6_game_over", int'(game_over), 1);
        chk("t6_round",     int'(round),     1);
        start = 1'b1;
        keypad_in = 4'b1001;
        @(negedge clk);
        keypad_in = 4'd0;
        @(negedge clk);
        keypad_in = 4'b0111;
        @(negedge clk);
        chk("t6_still_over", int'(game_over), 1);
        chk("t6_who_idle",   int'(who),       0);
        chk("t6_round_kept", int'(round),     1);
        start = 1'b0;
        win_sig = 2'b00;
        keypad_in = 4'd0;

        apply_reset(1'b0);
        @(negedge clk);
        chk("final_game_over_cleared", int'(game_over), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
